// File: rtl/vga_rx_pkg.sv
// Shared types and widths for the VGA timing receiver.
// Counter widths and the lock-state encoding live here so every file agrees.
package vga_rx_pkg;

    localparam int CNT_W   = 12;
    localparam int ERR_W   = 8;
    localparam int FRAME_W = 16;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_sync_edge_detect.sv
// Assert-edge (high-to-low) detector for an active-low sync line.
// Both the history register and the strobe only advance on pixel-enable cycles.
module vga_sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic pix_ce,
    input  logic sync_n,
    output logic assert_edge
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!reset)
            prev <= 1'b1;
        else if (pix_ce)
            prev <= sync_n;
    end

    assign assert_edge = pix_ce & prev & ~sync_n;

endmodule

// File: rtl/vga_timing_receiver.sv
// VGA sink: measures line/frame periods, locks to the nominal timing and
// emits a coordinate-tagged pixel stream plus frame and error statistics.
module vga_timing_receiver
    import vga_rx_pkg::*;
#(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    input  logic               vga_hsync,
    input  logic               vga_vsync,
    input  logic [7:0]         vga_red,
    input  logic [7:0]         vga_green,
    input  logic [7:0]         vga_blue,
    input  logic               vga_blank,
    output logic               locked,
    output logic               pix_valid,
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic [23:0]        pix_rgb,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count,
    output logic [CNT_W-1:0]   h_total_meas,
    output logic [CNT_W-1:0]   v_total_meas,
    output logic               timing_error,
    output logic [ERR_W-1:0]   err_count
);

    localparam logic [CNT_W-1:0] H_TOTAL_C  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_TOTAL_C  = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);
    // h_cnt saturates at 4095, so a longer timeout would never be reachable
    localparam logic [CNT_W-1:0] TIMEOUT_C  =
        CNT_W'((2 * H_TOTAL > 4095) ? 4095 : 2 * H_TOTAL);

    rx_state_t        state, state_next;
    logic             hs_edge, vs_edge;
    logic [CNT_W-1:0] h_cnt, line_cnt, x_cnt, y_cnt;
    logic [CNT_W-1:0] v_new, h_latest, x_eff, y_eff;
    logic             line_active, active, in_range;
    logic             lose_lock, range_err, frame_evt, pix_ok;

    vga_sync_edge_detect u_hs_edge (
        .clk         (clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .sync_n      (vga_hsync),
        .assert_edge (hs_edge)
    );

    vga_sync_edge_detect u_vs_edge (
        .clk         (clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .sync_n      (vga_vsync),
        .assert_edge (vs_edge)
    );

    // Values as they will be after this pix_ce cycle's sync edges are applied
    assign v_new    = line_cnt + {{(CNT_W-1){1'b0}}, hs_edge};
    assign h_latest = hs_edge ? h_cnt : h_total_meas;
    assign x_eff    = hs_edge ? '0 : x_cnt;
    assign y_eff    = vs_edge ? '0 :
                      (hs_edge && line_active) ? y_cnt + CNT_W'(1) : y_cnt;
    assign active   = pix_ce & ~vga_blank;
    assign in_range = (x_eff < H_ACTIVE_C) && (y_eff < V_ACTIVE_C);
    assign locked   = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (!reset)
            state <= SEARCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        lose_lock  = 1'b0;
        range_err  = 1'b0;
        frame_evt  = 1'b0;
        pix_ok     = 1'b0;
        if (pix_ce) begin
            unique case (state)
                SEARCH: begin
                    if (vs_edge)
                        state_next = ACQUIRE;
                end
                ACQUIRE: begin
                    if (vs_edge && v_new == V_TOTAL_C && h_latest == H_TOTAL_C)
                        state_next = LOCKED;
                end
                LOCKED: begin
                    lose_lock = (hs_edge && h_cnt != H_TOTAL_C) ||
                                (vs_edge && v_new != V_TOTAL_C) ||
                                (!hs_edge && h_cnt >= TIMEOUT_C);
                    if (lose_lock) begin
                        state_next = SEARCH;
                    end else begin
                        frame_evt = vs_edge;
                        if (active) begin
                            pix_ok    = in_range;
                            range_err = !in_range;
                        end
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    // Period measurement and raster position tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt        <= '0;
            line_cnt     <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            line_active  <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
        end else if (pix_ce) begin
            if (hs_edge) begin
                h_total_meas <= h_cnt;
                h_cnt        <= CNT_W'(1);
            end else begin
                h_cnt <= sat_inc(h_cnt);
            end
            if (vs_edge) begin
                v_total_meas <= v_new;
                line_cnt     <= '0;
            end else if (hs_edge) begin
                line_cnt <= line_cnt + CNT_W'(1);
            end
            y_cnt <= y_eff;
            if (active) begin
                x_cnt       <= sat_inc(x_eff);
                line_active <= 1'b1;
            end else begin
                x_cnt       <= x_eff;
                line_active <= line_active & ~hs_edge;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_rgb      <= '0;
            frame_start  <= 1'b0;
            frame_count  <= '0;
            timing_error <= 1'b0;
            err_count    <= '0;
        end else begin
            pix_valid    <= pix_ok;
            frame_start  <= frame_evt;
            timing_error <= lose_lock | range_err;
            if (pix_ok) begin
                pix_x   <= x_eff;
                pix_y   <= y_eff;
                pix_rgb <= {vga_red, vga_green, vga_blue};
            end
            if (frame_evt)
                frame_count <= frame_count + FRAME_W'(1);
            if ((lose_lock || range_err) && err_count != {ERR_W{1'b1}})
                err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
Sink end of the VGA interface driven by microprocessor_system_with_display. Samples hsync/vsync/blank/RGB, measures line and frame periods, and locks to the expected timing. Once locked, emits a coordinate-tagged pixel stream plus frame and error statistics. Used as a synthesizable checker and capture front-end in system benches, and as the input stage of a future frame-capture path.

Parameters:
H_TOTAL, 800, expected pixels per line (sync edge to sync edge); max 4095
V_TOTAL, 525, expected lines per frame; max 4095
H_ACTIVE, 640, maximum active (unblanked) pixels per line
V_ACTIVE, 480, maximum active lines per frame

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low
pix_ce  in  1  pixel-rate enable; all sampling and counting happen only on clk edges with pix_ce=1
vga_hsync  in  1  active-low horizontal sync
vga_vsync  in  1  active-low vertical sync
vga_red  in  8  red component
vga_green  in  8  green component
vga_blue  in  8  blue component
vga_blank  in  1  1 = blanking interval
locked  out  1  timing lock established
pix_valid  out  1  one-cycle strobe: captured active pixel
pix_x  out  12  active pixel column
pix_y  out  12  active line index
pix_rgb  out  24  {red, green, blue}
frame_start  out  1  one-cycle pulse on each vsync assert edge while locked
frame_count  out  16  locked frames seen; wraps at 0xFFFF->0
h_total_meas  out  12  last measured line period
v_total_meas  out  12  last measured frame period in lines
timing_error  out  1  one-cycle pulse on any error
err_count  out  8  saturating error count; holds at 255

Behaviour:
- Reset (reset=0 at a clk edge): all outputs 0; state SEARCH; internal counters 0; prev-sync registers 1. reset overrides pix_ce and takes effect mid-frame.
- Edge detect: an assert edge is prev=1 and current=0, evaluated on pix_ce cycles only. The prev register updates on pix_ce only.
- h_cnt, 12 bits: on an hsync edge, h_total_meas<=h_cnt and h_cnt<=1. Otherwise h_cnt<=h_cnt+1, saturating at 4095.
- line_cnt:
  - vsync edge: v_total_meas<=line_cnt+(hsync edge this cycle ?1:0); line_cnt<=0.
  - hsync edge only: line_cnt+1.
- State machine, transitions on pix_ce:
  - SEARCH: first vsync edge -> ACQUIRE.
  - ACQUIRE: on each vsync edge, if the new v_total_meas==V_TOTAL and the latest h_total_meas==H_TOTAL -> LOCKED. Otherwise stay in ACQUIRE (not an error). locked=1 in LOCKED only.
  - LOCKED, checks:
    - hsync edge with measured period != H_TOTAL -> error, go to SEARCH.
    - vsync edge with measured lines != V_TOTAL -> error, go to SEARCH.
    - h_cnt reaching 2*H_TOTAL without an hsync edge -> timeout error, go to SEARCH.
  - LOCKED, normal vsync edge: frame_start=1, frame_count+1.
- Error: timing_error pulses 1 cycle; err_count+1, saturating.
- Pixel path, LOCKED only:
  - An active pixel is vga_blank=0 on a pix_ce cycle.
  - x_cnt resets at an hsync edge and increments per active pixel.
  - y_cnt increments at an hsync edge if the finished line had ≥1 active pixel; resets at a vsync edge.
  - A valid pixel requires x_cnt<H_ACTIVE and y_cnt<V_ACTIVE. Then pix_valid=1, pix_x=x_cnt, pix_y=y_cnt, pix_rgb={r,g,b} registered, visible 1 clk after the sampling edge.
  - An out-of-range active pixel -> error pulse, err_count+1, stays LOCKED, no pix_valid.
- pix_x, pix_y and pix_rgb hold their values when pix_valid=0.
- Simultaneous error and frame_start: only one error is counted; frame_start is suppressed because lock is lost.

Decomposition:
- Package vga_rx_pkg:
  - state enum (SEARCH/ACQUIRE/LOCKED)
  - CNT_W=12, ERR_W=8, FRAME_W=16
- Sub-module vga_sync_edge_detect: one instance per sync, outputs the assert-edge strobe on pix_ce.

Test Plan:
1. Reset and idle -> hold reset=0 for 5 cycles then release, with syncs high and pix_ce toggling -> all outputs 0 and locked=0 after 100 pix_ce.
2. Nominal lock (H_TOTAL=20, H_ACTIVE=12, V_TOTAL=10, V_ACTIVE=6, pix_ce every 4th clk, 3 ideal frames):
   - locked rises at the 2nd vsync edge; h_total_meas=20, v_total_meas=10.
   - 3rd frame: exactly 72 pix_valid, x 0..11, y 0..5, RGB matches the driven ramp.
   - frame_start fires once; frame_count=1.
3. Locked, one line stretched to 21 pixels -> timing_error 1 pulse, err_count=1, locked=0; relocks after 2 further clean frames.
4. Locked, hsync held high -> timeout at h_cnt=40, err_count+1, state SEARCH, no pix_valid afterwards.
5. Coincident hsync and vsync assert edges with 9 prior lines -> v_total_meas=10, line_cnt=0, lock kept; 13 active pixels on one line -> 12 pix_valid plus 1 error.
6. reset=0 mid-frame while locked -> next clk: all outputs 0; after release, relock after 2 frames; err_count restarts at 0.
